// File: rtl/video_syn_gen_if.sv
// Video timing generator bundle: run/polarity controls in, sync/DE/active-area
// coordinates and the frame-start pulse out. The generator takes the master
// modport; the pixel-fetch side (or a bench) takes the slave modport.
interface video_syn_gen_if #(
    parameter int CW = 12
);
    // Controls sampled by the generator
    logic          i_en;
    logic          i_hsyn_pol;
    logic          i_vsyn_pol;

    // Registered timing outputs, all mutually aligned
    logic          o_video_hsyn;
    logic          o_video_vsyn;
    logic          o_video_de;
    logic [CW-1:0] o_act_x;
    logic [CW-1:0] o_act_y;
    logic          o_frame_start;

    modport master (
        input  i_en,
        input  i_hsyn_pol,
        input  i_vsyn_pol,
        output o_video_hsyn,
        output o_video_vsyn,
        output o_video_de,
        output o_act_x,
        output o_act_y,
        output o_frame_start
    );

    modport slave (
        output i_en,
        output i_hsyn_pol,
        output i_vsyn_pol,
        input  o_video_hsyn,
        input  o_video_vsyn,
        input  o_video_de,
        input  o_act_x,
        input  o_act_y,
        input  o_frame_start
    );
endinterface

// File: rtl/video_syn_gen.sv
// Video timing generator. Free-running pixel (h) and line (v) counters are
// decoded into raw hsync/vsync/DE and active-area x/y; everything is registered
// once so all outputs are aligned one cycle behind the counter state.
// Sync polarity is latched once per frame, at counter state (0,0), so a
// polarity change on the inputs never produces a partial pulse mid-frame.
module video_syn_gen #(
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int CW       = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    video_syn_gen_if.master   vif
);

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_DE_BEG = H_SYNC + H_BP;
    localparam int H_DE_END = H_DE_BEG + H_ACTIVE;   // exclusive
    localparam int V_DE_BEG = V_SYNC + V_BP;
    localparam int V_DE_END = V_DE_BEG + V_ACTIVE;   // exclusive

    localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_C   = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C   = CW'(V_SYNC);
    localparam logic [CW-1:0] H_DE_BEG_C = CW'(H_DE_BEG);
    localparam logic [CW-1:0] H_DE_END_C = CW'(H_DE_END);
    localparam logic [CW-1:0] V_DE_BEG_C = CW'(V_DE_BEG);
    localparam logic [CW-1:0] V_DE_END_C = CW'(V_DE_END);

    // Counter state
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;

    // Per-frame polarity registers
    logic          hpol_q, hpol_d;
    logic          vpol_q, vpol_d;

    // Output registers
    logic          hsyn_q, hsyn_d;
    logic          vsyn_q, vsyn_d;
    logic          de_q, de_d;
    logic [CW-1:0] act_x_q, act_x_d;
    logic [CW-1:0] act_y_q, act_y_d;
    logic          fs_q, fs_d;

    // Decode helpers
    logic          h_last;
    logic          v_last;
    logic          origin;
    logic          hsyn_raw;
    logic          vsyn_raw;
    logic          h_act;
    logic          v_act;
    logic          de_raw;
    logic          hpol_eff;
    logic          vpol_eff;

    assign h_last = (h_cnt_q == H_LAST_C);
    assign v_last = (v_cnt_q == V_LAST_C);

    // Counter next-state: wrap h every line, advance v on h wrap, park at origin when disabled
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!vif.i_en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    // Raw timing decode of the current counter state
    always_comb begin
        origin   = vif.i_en && (h_cnt_q == '0) && (v_cnt_q == '0);
        hsyn_raw = vif.i_en && (h_cnt_q < H_SYNC_C);
        vsyn_raw = vif.i_en && (v_cnt_q < V_SYNC_C);
        h_act    = (h_cnt_q >= H_DE_BEG_C) && (h_cnt_q < H_DE_END_C);
        v_act    = (v_cnt_q >= V_DE_BEG_C) && (v_cnt_q < V_DE_END_C);
        de_raw   = vif.i_en && h_act && v_act;
    end

    // Polarity: load at frame origin, and let the origin cycle itself use the new value
    always_comb begin
        hpol_d   = hpol_q;
        vpol_d   = vpol_q;
        if (origin) begin
            hpol_d = vif.i_hsyn_pol;
            vpol_d = vif.i_vsyn_pol;
        end
        hpol_eff = hpol_d;
        vpol_eff = vpol_d;
    end

    // Output next-state: apply polarity (raw XNOR pol) and form active-area coordinates
    always_comb begin
        hsyn_d  = ~(hsyn_raw ^ hpol_eff);
        vsyn_d  = ~(vsyn_raw ^ vpol_eff);
        de_d    = de_raw;
        fs_d    = origin;
        act_x_d = '0;
        act_y_d = '0;
        if (de_raw) begin
            act_x_d = h_cnt_q - H_DE_BEG_C;
            act_y_d = v_cnt_q - V_DE_BEG_C;
        end
    end

    // State and output registers; reset lands on origin, active-high polarity, all outputs low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hpol_q  <= 1'b1;
            vpol_q  <= 1'b1;
            hsyn_q  <= 1'b0;
            vsyn_q  <= 1'b0;
            de_q    <= 1'b0;
            act_x_q <= '0;
            act_y_q <= '0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hpol_q  <= hpol_d;
            vpol_q  <= vpol_d;
            hsyn_q  <= hsyn_d;
            vsyn_q  <= vsyn_d;
            de_q    <= de_d;
            act_x_q <= act_x_d;
            act_y_q <= act_y_d;
            fs_q    <= fs_d;
        end
    end

    assign vif.o_video_hsyn  = hsyn_q;
    assign vif.o_video_vsyn  = vsyn_q;
    assign vif.o_video_de    = de_q;
    assign vif.o_act_x       = act_x_q;
    assign vif.o_act_y       = act_y_q;
    assign vif.o_frame_start = fs_q;

endmodule

// File: tb/tb_video_syn_gen.sv
// Directed bench for video_syn_gen with a small raster:
// H 2/2/8/2 (14 clocks/line), V 1/1/4/1 (7 lines), 98 clocks per frame.
// Output sample c (taken #1 after the c-th clock edge of a run) reflects
// counter state h = c%14, line = (c/14)%7.
`timescale 1ns/1ps
module tb_video_syn_gen;

    localparam int CW      = 12;
    localparam int H_TOT   = 14;
    localparam int FRAME   = 98;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    // Per-run tallies used for hand-counted totals
    int cnt_de, cnt_fs, cnt_hs, cnt_vs, max_x, max_y;

    video_syn_gen_if #(.CW(CW)) vif ();

    video_syn_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .CW(CW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .vif    (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tallies();
        cnt_de = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; max_x = 0; max_y = 0;
    endtask

    // Run n clocks from a frame origin, checking every output each clock.
    // Polarity inputs switch to hp1/vp1 before clock chg_at (-1: never);
    // the new polarity is expected from the first frame origin at or after chg_at.
    task automatic run_seq(input int n, input bit hp0, input bit vp0,
                           input bit hp1, input bit vp1, input int chg_at, input string nm);
        int  h, l, new_from;
        bit  hp, vp, hs, vs, de, fs;
        int  x, y;
        new_from = (chg_at < 0) ? 1 << 30 : ((chg_at + FRAME - 1) / FRAME) * FRAME;
        for (int c = 0; c < n; c++) begin
            if (c == chg_at) begin
                vif.i_hsyn_pol = hp1;
                vif.i_vsyn_pol = vp1;
            end
            @(posedge clk);
            #1;
            h  = c % H_TOT;
            l  = (c / H_TOT) % 7;
            hp = (c >= new_from) ? hp1 : hp0;
            vp = (c >= new_from) ? vp1 : vp0;
            hs = ((h < 2) == hp);
            vs = ((l < 1) == vp);
            de = (h >= 4) && (h < 12) && (l >= 2) && (l < 6);
            fs = (c % FRAME) == 0;
            x  = de ? h - 4 : 0;
            y  = de ? l - 2 : 0;
            chk($sformatf("%s hsyn@%0d", nm, c), 32'(vif.o_video_hsyn), 32'(hs));
            chk($sformatf("%s vsyn@%0d", nm, c), 32'(vif.o_video_vsyn), 32'(vs));
            chk($sformatf("%s de@%0d", nm, c), 32'(vif.o_video_de), 32'(de));
            chk($sformatf("%s fs@%0d", nm, c), 32'(vif.o_frame_start), 32'(fs));
            chk($sformatf("%s x@%0d", nm, c), 32'(vif.o_act_x), 32'(x));
            chk($sformatf("%s y@%0d", nm, c), 32'(vif.o_act_y), 32'(y));
            if (vif.o_video_de === 1'b1) cnt_de++;
            if (vif.o_frame_start === 1'b1) cnt_fs++;
            if (vif.o_video_hsyn === 1'b1) cnt_hs++;
            if (vif.o_video_vsyn === 1'b1) cnt_vs++;
            if (int'(vif.o_act_x) > max_x) max_x = int'(vif.o_act_x);
            if (int'(vif.o_act_y) > max_y) max_y = int'(vif.o_act_y);
        end
        $display("run %s: %0d clocks, de=%0d fs=%0d hs_hi=%0d vs_hi=%0d", nm, n, cnt_de, cnt_fs, cnt_hs, cnt_vs);
    endtask

    // One clock with i_en low: everything inactive at the held polarity
    task automatic idle_clock(input bit hp, input bit vp, input string nm);
        @(posedge clk);
        #1;
        chk({nm, " hsyn"}, 32'(vif.o_video_hsyn), 32'(!hp));
        chk({nm, " vsyn"}, 32'(vif.o_video_vsyn), 32'(!vp));
        chk({nm, " de"}, 32'(vif.o_video_de), 32'd0);
        chk({nm, " fs"}, 32'(vif.o_frame_start), 32'd0);
        chk({nm, " x"}, 32'(vif.o_act_x), 32'd0);
        chk({nm, " y"}, 32'(vif.o_act_y), 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " hsyn"}, 32'(vif.o_video_hsyn), 32'd0);
        chk({nm, " vsyn"}, 32'(vif.o_video_vsyn), 32'd0);
        chk({nm, " de"}, 32'(vif.o_video_de), 32'd0);
        chk({nm, " fs"}, 32'(vif.o_frame_start), 32'd0);
        chk({nm, " x"}, 32'(vif.o_act_x), 32'd0);
        chk({nm, " y"}, 32'(vif.o_act_y), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        vif.i_en       = 1'b0;
        vif.i_hsyn_pol = 1'b1;
        vif.i_vsyn_pol = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        $display("reset: outputs checked");

        // Case 1/2: release with en=1, two frames active-high
        rst_n    = 1'b1;
        vif.i_en = 1'b1;
        clear_tallies();
        run_seq(2 * FRAME, 1'b1, 1'b1, 1'b1, 1'b1, -1, "c1");
        chk("c1 de count", 32'(cnt_de), 32'd64);
        chk("c1 fs count", 32'(cnt_fs), 32'd2);
        chk("c1 hs high", 32'(cnt_hs), 32'd28);
        chk("c1 vs high", 32'(cnt_vs), 32'd28);
        chk("c2 max x", 32'(max_x), 32'd7);
        chk("c2 max y", 32'(max_y), 32'd3);

        // Case 3: polarity 0/0 from a fresh frame start
        vif.i_en       = 1'b0;
        vif.i_hsyn_pol = 1'b0;
        vif.i_vsyn_pol = 1'b0;
        idle_clock(1'b1, 1'b1, "c3 idle");
        vif.i_en = 1'b1;
        clear_tallies();
        run_seq(FRAME, 1'b0, 1'b0, 1'b0, 1'b0, -1, "c3");
        chk("c3 de count", 32'(cnt_de), 32'd32);
        chk("c3 hs high", 32'(cnt_hs), 32'd84);
        chk("c3 vs high", 32'(cnt_vs), 32'd84);

        // Case 4: back to 1/1, then vsync polarity drops at clock 40
        vif.i_hsyn_pol = 1'b1;
        vif.i_vsyn_pol = 1'b1;
        clear_tallies();
        run_seq(2 * FRAME, 1'b1, 1'b1, 1'b1, 1'b0, 40, "c4");
        chk("c4 vs high", 32'(cnt_vs), 32'd14 + 32'd84);

        // Case 5: drop en at clock 50 for 10 clocks, then a clean frame
        vif.i_vsyn_pol = 1'b1;
        clear_tallies();
        run_seq(50, 1'b1, 1'b1, 1'b1, 1'b1, -1, "c5a");
        vif.i_en = 1'b0;
        for (int i = 0; i < 10; i++) idle_clock(1'b1, 1'b1, $sformatf("c5 idle%0d", i));
        vif.i_en = 1'b1;
        clear_tallies();
        run_seq(FRAME, 1'b1, 1'b1, 1'b1, 1'b1, -1, "c5b");
        chk("c5 fs count", 32'(cnt_fs), 32'd1);
        chk("c5 de count", 32'(cnt_de), 32'd32);

        // Case 6: async reset in the middle of an active line (line 2, h=5)
        clear_tallies();
        run_seq(34, 1'b1, 1'b1, 1'b1, 1'b1, -1, "c6a");
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("c6 async");
        @(posedge clk);
        #1;
        chk_all_zero("c6 held");
        rst_n = 1'b1;
        clear_tallies();
        run_seq(3 * H_TOT, 1'b1, 1'b1, 1'b1, 1'b1, -1, "c6b");
        chk("c6 fs count", 32'(cnt_fs), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
